keypad_scanner: RTL

Column-strobing scan controller for the 4x4 matrix keypad. It drives one active-low column at a time and samples the synchronized rows. On a press it freezes the column and hands the row pattern to the downstream `debouncer` as its `criterion`. It then waits for that debouncer's `steady`, emits one key code, and waits for a debounced release before it resumes scanning.

---
 rtl/keypad_scanner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-strobing 4x4 keypad scan controller driving an external debouncer
// Optional feature macro: KEYPAD_MULTIKEY_REJECT_EN (reject samples with more than one pressed row)
module keypad_scanner #(
    parameter logic [31:0] SCAN_DIV = 32'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       steady,
    output logic [3:0] cols,
    output logic [3:0] db_in,
    output logic [3:0] db_criterion,
    output logic       db_en,
    output logic       db_clr,
    output logic [3:0] key_code,
    output logic       key_valid
);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        EMIT       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  sync1;
    logic [1:0]  col_idx;
    logic [3:0]  row_pat;
    logic [31:0] dwell;
    logic        sample_press;
    logic        press_abort;

    // True when more than one row line is pulled low.
    function automatic logic multi_zero(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) n++;
        end
        return (n > 1);
    endfunction

    // Index of the lowest-numbered low row line.
    function automatic logic [1:0] low_zero(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign sample_press = (db_in != 4'hF) && !multi_zero(db_in);
    assign press_abort  = (db_in == 4'hF) || multi_zero(db_in);
`else
    assign sample_press = (db_in != 4'hF);
    assign press_abort  = (db_in == 4'hF);
`endif

    // Two-flop synchronizer for the asynchronous row lines; idle rows read all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'hF;
            db_in <= 4'hF;
        end else begin
            sync1 <= rows;
            db_in <= sync1;
        end
    end

    // Scan / debounce-press / emit / debounce-release sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SCAN;
            cols         <= 4'b1110;
            col_idx      <= 2'd0;
            dwell        <= 32'd0;
            row_pat      <= 4'hF;
            db_criterion <= 4'hF;
            db_en        <= 1'b0;
            db_clr       <= 1'b0;
            key_code     <= 4'h0;
            key_valid    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            db_clr    <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == SCAN_DIV - 32'd1) begin
                        dwell <= 32'd0;
                        if (sample_press) begin
                            // Freeze on this column; col_idx already names it.
                            row_pat      <= db_in;
                            db_criterion <= db_in;
                            db_en        <= 1'b1;
                            db_clr       <= 1'b1;
                            state        <= PRESS_DB;
                        end else begin
                            cols    <= {cols[2:0], cols[3]};
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 32'd1;
                    end
                end
                PRESS_DB: begin
                    // steady takes priority over a simultaneous bounce-out.
                    if (steady) begin
                        key_valid    <= 1'b1;
                        key_code     <= {low_zero(row_pat), col_idx};
                        db_en        <= 1'b0;
                        db_criterion <= 4'hF;
                        state        <= EMIT;
                    end else if (press_abort) begin
                        db_en        <= 1'b0;
                        db_criterion <= 4'hF;
                        cols         <= {cols[2:0], cols[3]};
                        col_idx      <= col_idx + 2'd1;
                        dwell        <= 32'd0;
                        state        <= SCAN;
                    end
                end
                EMIT: begin
                    db_clr       <= 1'b1;
                    db_en        <= 1'b1;
                    db_criterion <= 4'hF;
                    state        <= RELEASE_DB;
                end
                RELEASE_DB: begin
                    if (steady) begin
                        db_en   <= 1'b0;
                        cols    <= {cols[2:0], cols[3]};
                        col_idx <= col_idx + 2'd1;
                        dwell   <= 32'd0;
                        state   <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
